// File: rtl/crc_serial_stream.sv
// Bit-serial CRC engine: shifts valid/ready words MSB-first, one bit per clock,
// and strobes the final (XOR_OUT applied) CRC when a word marked last completes.
module crc_serial_stream #(
  parameter int                 CRC_W   = 16,
  parameter logic [CRC_W-1:0]   POLY    = 16'h1021,
  parameter logic [CRC_W-1:0]   INIT    = '0,
  parameter logic [CRC_W-1:0]   XOR_OUT = '0,
  parameter int                 DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_valid,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

  logic [0:0]        state_q, state_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [CRC_W-1:0]  out_q, out_d;
  logic              vld_q, vld_d;

  logic              fb;
  logic [CRC_W-1:0]  crc_nx;

  // One LFSR step: feedback is the CRC MSB mixed with the next message bit
  always_comb begin
    fb     = crc_q[CRC_W-1] ^ sh_q[DATA_W-1];
    crc_nx = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  // Next-state: accept in IDLE, shift in SHIFT; clear wins over both
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      crc_d   = INIT;
      last_d  = 1'b0;
    end else begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          if (in_valid) begin
            sh_d    = in_data;
            last_d  = in_last;
            cnt_d   = CNT_TOP;
            state_d = S_SHIFT;
          end
        end
        (state_q == S_SHIFT): begin
          crc_d = crc_nx;
          sh_d  = sh_q << 1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            if (last_q) begin
              out_d  = crc_nx ^ XOR_OUT;
              vld_d  = 1'b1;
              crc_d  = INIT;
              last_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      crc_q   <= INIT;
      sh_q    <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_SHIFT);
  assign crc_out   = out_q;
  assign crc_valid = vld_q;

endmodule

// File: tb/tb_crc_serial_stream.sv
// Scoreboard bench for crc_serial_stream: three configurations driven with
// directed byte messages; a negedge monitor pops expected CRC and cycle.
module tb_crc_serial_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       v[3];
  logic       l[3];
  logic [7:0] dat[3];
  logic       rdy[3];
  logic       vld[3];
  logic       bsy[3];
  logic [15:0] co0, co1;
  logic [7:0]  co2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] crc;
    int          at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  crc_serial_stream #(
    .CRC_W(16), .POLY(16'h1021), .INIT(16'h0000),
    .XOR_OUT(16'h0000), .DATA_W(8)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(v[0]), .in_ready(rdy[0]), .in_data(dat[0]),
    .in_last(l[0]), .crc_out(co0), .crc_valid(vld[0]),
    .busy(bsy[0])
  );

  crc_serial_stream #(
    .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF),
    .XOR_OUT(16'h0000), .DATA_W(8)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .clear(1'b0),
    .in_valid(v[1]), .in_ready(rdy[1]), .in_data(dat[1]),
    .in_last(l[1]), .crc_out(co1), .crc_valid(vld[1]),
    .busy(bsy[1])
  );

  crc_serial_stream #(
    .CRC_W(8), .POLY(8'h07), .INIT(8'h00),
    .XOR_OUT(8'h00), .DATA_W(8)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .clear(1'b0),
    .in_valid(v[2]), .in_ready(rdy[2]), .in_data(dat[2]),
    .in_last(l[2]), .crc_out(co2), .crc_valid(vld[2]),
    .busy(bsy[2])
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(int d, logic [15:0] e, int at);
    exp_t x;
    x.crc = e;
    x.at  = at;
    case (d)
      0:       q0.push_back(x);
      1:       q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  // Monitor: every crc_valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (vld[d] === 1'b1) begin
        exp_t x;
        bit   have;
        logic [15:0] act;
        have = 1'b0;
        act  = '0;
        case (d)
          0: begin
            act = co0;
            if (q0.size() > 0) begin x = q0.pop_front(); have = 1'b1; end
          end
          1: begin
            act = co1;
            if (q1.size() > 0) begin x = q1.pop_front(); have = 1'b1; end
          end
          default: begin
            act = {8'h00, co2};
            if (q2.size() > 0) begin x = q2.pop_front(); have = 1'b1; end
          end
        endcase
        if (!have) begin
          chk($sformatf("spurious_valid_u%0d", d), 32'd1, 32'd0);
        end else begin
          chk($sformatf("crc_u%0d", d), {16'h0, act}, {16'h0, x.crc});
          chk($sformatf("latency_u%0d", d), cyc, x.at);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance (or later)
  task automatic send(int d, logic [7:0] b, logic lst, bit rchk,
                      bit pe, logic [15:0] e);
    int n;
    n = 0;
    v[d]   = 1'b1;
    dat[d] = b;
    l[d]   = lst;
    while (rdy[d] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    v[d] = 1'b0;
    l[d] = 1'b0;
    if (lst && pe) push(d, e, cyc + 8);
    if (rchk) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        chk("ready_low", {31'h0, rdy[d]}, 32'd0);
      end
      @(negedge clk);
      chk("ready_back", {31'h0, rdy[d]}, 32'd1);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic msg9(int d, logic [15:0] e, bit rchk);
    for (int i = 0; i < 9; i++)
      send(d, 8'(8'h31 + i), (i == 8), rchk, 1'b1, e);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    clear = 1'b0;
    for (int d = 0; d < 3; d++) begin
      v[d]   = 1'b0;
      l[d]   = 1'b0;
      dat[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_crc_out", {16'h0, co0}, 32'h0);
    chk("rst_valid", {31'h0, vld[0]}, 32'd0);
    chk("rst_busy", {31'h0, bsy[0]}, 32'd0);
    chk("rst_ready", {31'h0, rdy[0]}, 32'd1);
    chk("rst_crc8_out", {24'h0, co2}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    send(0, 8'h01, 1'b1, 1'b0, 1'b1, 16'h1021);

    msg9(0, 16'h31C3, 1'b1);

    msg9(1, 16'h29B1, 1'b0);
    msg9(1, 16'h29B1, 1'b0);

    msg9(2, 16'h00F4, 1'b0);

    for (int i = 0; i < 4; i++)
      send(0, 8'(8'h31 + i), 1'b0, 1'b0, 1'b0, 16'h0);
    send(0, 8'h35, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (3) @(negedge clk);
    chk("busy_before_clear", {31'h0, bsy[0]}, 32'd1);
    clear  = 1'b1;
    v[0]   = 1'b1;
    dat[0] = 8'h36;
    l[0]   = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    v[0]  = 1'b0;
    l[0]  = 1'b0;
    @(negedge clk);
    chk("clear_busy", {31'h0, bsy[0]}, 32'd0);
    chk("clear_ready", {31'h0, rdy[0]}, 32'd1);
    chk("clear_hold_out", {16'h0, co0}, 32'h31C3);
    msg9(0, 16'h31C3, 1'b0);

    send(0, 8'h31, 1'b1, 1'b0, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_no_effect_busy", {31'h0, bsy[0]}, 32'd1);
    chk("async_no_effect_ready", {31'h0, rdy[0]}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {31'h0, vld[0]}, 32'd0);
    chk("midrst_busy", {31'h0, bsy[0]}, 32'd0);
    chk("midrst_ready", {31'h0, rdy[0]}, 32'd1);
    chk("midrst_crc_out", {16'h0, co0}, 32'h0);
    repeat (12) @(negedge clk);

    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q0.size() + q1.size() + q2.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
